// File: rtl/ram_operand_unit_pkg.sv
// Shared encodings for the RAM operand sequencer: addressing modes, FSM state codes
// and the request fields held for the lifetime of one operation.
package ram_ops_pkg;

  localparam logic [1:0] MODE_DIRECT = 2'b00;
  localparam logic [1:0] MODE_REG    = 2'b01;
  localparam logic [1:0] MODE_IND    = 2'b10;
  localparam logic [1:0] MODE_BIT    = 2'b11;

  localparam logic [7:0] BIT_BASE_DEF = 8'h20;
  localparam logic [7:0] SFR_BASE_DEF = 8'h80;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_PTR_RD  = 3'd1;
  localparam logic [2:0] ST_PTR_CAP = 3'd2;
  localparam logic [2:0] ST_ACCESS  = 3'd3;
  localparam logic [2:0] ST_CAPTURE = 3'd4;

  typedef struct packed {
    logic       we;
    logic       is_bit;
    logic [7:0] wdata;
    logic       wbit;
  } req_t;

endpackage

// File: rtl/ram_operand_unit_bit_addr_map.sv
// Maps an 8051 bit address onto the RAM byte that holds it plus the bit selector.
// Low bit space lives in the bit-addressable LRAM block, high space in bit-addressable SFRs.
module bit_addr_map #(
  parameter int unsigned       ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] BIT_BASE = 8'h20,
  parameter logic [ADDR_W-1:0] SFR_BASE = 8'h80
) (
  input  logic [ADDR_W-1:0] bit_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [ADDR_W-1:0] bit_addr_o
);

  always_comb begin
    if (bit_i < SFR_BASE) begin
      addr_o     = BIT_BASE + ADDR_W'(bit_i[6:3]);
      bit_addr_o = bit_i;
    end else begin
      addr_o     = {bit_i[ADDR_W-1:3], 3'b000};
      bit_addr_o = ADDR_W'(bit_i[2:0]);
    end
  end

endmodule

// File: rtl/ram_operand_unit.sv
// Sequences one core operand request (direct, Rn, @Ri, bit) into registered memory_ram
// strobes and returns the read byte/bit with a single-cycle done pulse.
module ram_operand_unit
  import ram_ops_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] BIT_BASE = 8'h20,
  parameter logic [ADDR_W-1:0] SFR_BASE = 8'h80
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [1:0]        mode_i,
  input  logic [ADDR_W-1:0] operand_i,
  input  logic [1:0]        psw_rs_i,
  input  logic [ADDR_W-1:0] wdata_i,
  input  logic              wbit_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] rdata_o,
  output logic              rbit_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_rd_o,
  output logic              ram_wr_o,
  output logic [ADDR_W-1:0] ram_wdata_o,
  output logic              ram_in_bit_o,
  output logic [ADDR_W-1:0] ram_bit_addr_o,
  output logic              ram_is_bit_o,
  output logic              ram_indirect_o,
  input  logic [ADDR_W-1:0] ram_out_i,
  input  logic              ram_out_bit_i
);

  logic [2:0]        state_q, state_d;
  req_t              req_q;
  logic              busy_q, done_q, rbit_q;
  logic [ADDR_W-1:0] rdata_q;
  logic [ADDR_W-1:0] ram_addr_q, ram_wdata_q, ram_bit_addr_q;
  logic              ram_rd_q, ram_wr_q, ram_in_bit_q, ram_is_bit_q, ram_indirect_q;

  logic              accept;
  logic [ADDR_W-1:0] map_addr, map_bit_addr;
  logic [ADDR_W-1:0] acc_addr, acc_bit_addr;

  bit_addr_map #(
    .ADDR_W  (ADDR_W),
    .BIT_BASE(BIT_BASE),
    .SFR_BASE(SFR_BASE)
  ) u_bit_map (
    .bit_i     (operand_i),
    .addr_o    (map_addr),
    .bit_addr_o(map_bit_addr)
  );

  assign accept = (state_q == ST_IDLE) && req_i;

  // First RAM address issued at accept; for @Ri this is the Ri cell holding the pointer.
  always_comb begin
    acc_addr     = operand_i;
    acc_bit_addr = '0;
    case (mode_i)
      MODE_DIRECT: acc_addr = operand_i;
      MODE_REG:    acc_addr = ADDR_W'({3'b000, psw_rs_i, operand_i[2:0]});
      MODE_IND:    acc_addr = ADDR_W'({3'b000, psw_rs_i, 2'b00, operand_i[0]});
      MODE_BIT: begin
        acc_addr     = map_addr;
        acc_bit_addr = map_bit_addr;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (req_i) state_d = (mode_i == MODE_IND) ? ST_PTR_RD : ST_ACCESS;
      ST_PTR_RD:  state_d = ST_PTR_CAP;
      ST_PTR_CAP: state_d = ST_ACCESS;
      ST_ACCESS:  state_d = req_q.we ? ST_IDLE : ST_CAPTURE;
      ST_CAPTURE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      req_q          <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      rdata_q        <= '0;
      rbit_q         <= 1'b0;
      ram_addr_q     <= '0;
      ram_rd_q       <= 1'b0;
      ram_wr_q       <= 1'b0;
      ram_wdata_q    <= '0;
      ram_in_bit_q   <= 1'b0;
      ram_bit_addr_q <= '0;
      ram_is_bit_q   <= 1'b0;
      ram_indirect_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ram_rd_q <= 1'b0;
      ram_wr_q <= 1'b0;
      done_q   <= 1'b0;

      if (accept) begin
        busy_q         <= 1'b1;
        req_q.we       <= we_i;
        req_q.is_bit   <= (mode_i == MODE_BIT);
        req_q.wdata    <= wdata_i;
        req_q.wbit     <= wbit_i;
        ram_addr_q     <= acc_addr;
        ram_bit_addr_q <= acc_bit_addr;
        ram_is_bit_q   <= (mode_i == MODE_BIT);
        ram_indirect_q <= 1'b0;
        if (mode_i == MODE_IND) begin
          ram_rd_q     <= 1'b1;
          ram_wdata_q  <= '0;
          ram_in_bit_q <= 1'b0;
        end else begin
          ram_rd_q     <= ~we_i;
          ram_wr_q     <= we_i;
          ram_wdata_q  <= wdata_i;
          ram_in_bit_q <= wbit_i;
        end
      end

      // Pointer arrives from RAM here; indirect flag keeps pointers >= 80h in upper IRAM.
      if (state_q == ST_PTR_CAP) begin
        ram_addr_q     <= ram_out_i;
        ram_indirect_q <= 1'b1;
        ram_rd_q       <= ~req_q.we;
        ram_wr_q       <= req_q.we;
        ram_wdata_q    <= req_q.wdata;
        ram_in_bit_q   <= req_q.wbit;
      end

      if ((state_q == ST_ACCESS && req_q.we) || state_q == ST_CAPTURE) begin
        done_q <= 1'b1;
        busy_q <= 1'b0;
      end

      if (state_q == ST_CAPTURE) begin
        if (req_q.is_bit) rbit_q  <= ram_out_bit_i;
        else              rdata_q <= ram_out_i;
      end
    end
  end

  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign rdata_o        = rdata_q;
  assign rbit_o         = rbit_q;
  assign ram_addr_o     = ram_addr_q;
  assign ram_rd_o       = ram_rd_q;
  assign ram_wr_o       = ram_wr_q;
  assign ram_wdata_o    = ram_wdata_q;
  assign ram_in_bit_o   = ram_in_bit_q;
  assign ram_bit_addr_o = ram_bit_addr_q;
  assign ram_is_bit_o   = ram_is_bit_q;
  assign ram_indirect_o = ram_indirect_q;

endmodule
